// File: rtl/hid_ps2_pkg.sv
// hid_ps2_pkg: shared FSM encoding, report layout, gap default and modifier
// scan codes for the HID boot-report to PS/2 set-2 encoder.
package hid_ps2_pkg;
    typedef enum logic [2:0] {IDLE, BRK_SCAN, MK_SCAN, EMIT_E0, EMIT_F0, EMIT_CODE, GAP, COMMIT} state_e;
    localparam int GAP_CYCLES_DEFAULT = 16;
    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } ps2_code_t;
    typedef struct packed {
        logic [7:0]      mods;
        logic [5:0][7:0] keys;
    } report_t;
    // {ext, code} per modifier bit, listed RGUI (bit7) down to LCtrl (bit0)
    localparam logic [7:0][8:0] MOD_CODES = {9'h127, 9'h111, 9'h059, 9'h114, 9'h11F, 9'h011, 9'h012, 9'h014};
endpackage

// File: rtl/hid_ps2_lut.sv
// hid_ps2_lut: maps a modifier index or HID usage to a set-2 make code plus
// E0 flag; a code of 0x00 marks an unmapped usage.
module hid_ps2_lut
    import hid_ps2_pkg::*;
(
    input  logic       is_mod_i,
    input  logic [7:0] usage_i,
    output ps2_code_t  code_o
);
    logic [8:0] key;
    always_comb begin
        case (usage_i)
            8'h04: key = 9'h01C;  8'h05: key = 9'h032;  8'h06: key = 9'h021;  8'h07: key = 9'h023;
            8'h08: key = 9'h024;  8'h09: key = 9'h02B;  8'h0A: key = 9'h034;  8'h0B: key = 9'h033;
            8'h0C: key = 9'h043;  8'h0D: key = 9'h03B;  8'h0E: key = 9'h042;  8'h0F: key = 9'h04B;
            8'h10: key = 9'h03A;  8'h11: key = 9'h031;  8'h12: key = 9'h044;  8'h13: key = 9'h04D;
            8'h14: key = 9'h015;  8'h15: key = 9'h02D;  8'h16: key = 9'h01B;  8'h17: key = 9'h02C;
            8'h18: key = 9'h03C;  8'h19: key = 9'h02A;  8'h1A: key = 9'h01D;  8'h1B: key = 9'h022;
            8'h1C: key = 9'h035;  8'h1D: key = 9'h01A;  8'h1E: key = 9'h016;  8'h1F: key = 9'h01E;
            8'h20: key = 9'h026;  8'h21: key = 9'h025;  8'h22: key = 9'h02E;  8'h23: key = 9'h036;
            8'h24: key = 9'h03D;  8'h25: key = 9'h03E;  8'h26: key = 9'h046;  8'h27: key = 9'h045;
            8'h28: key = 9'h05A;  8'h29: key = 9'h076;  8'h2A: key = 9'h066;  8'h2B: key = 9'h00D;
            8'h2C: key = 9'h029;  8'h2D: key = 9'h04E;  8'h2E: key = 9'h055;  8'h2F: key = 9'h054;
            8'h30: key = 9'h05B;  8'h31: key = 9'h05D;  8'h32: key = 9'h05D;  8'h33: key = 9'h04C;
            8'h34: key = 9'h052;  8'h35: key = 9'h00E;  8'h36: key = 9'h041;  8'h37: key = 9'h049;
            8'h38: key = 9'h04A;  8'h39: key = 9'h058;  8'h3A: key = 9'h005;  8'h3B: key = 9'h006;
            8'h3C: key = 9'h004;  8'h3D: key = 9'h00C;  8'h3E: key = 9'h003;  8'h3F: key = 9'h00B;
            8'h40: key = 9'h083;  8'h41: key = 9'h00A;  8'h42: key = 9'h001;  8'h43: key = 9'h009;
            8'h44: key = 9'h078;  8'h45: key = 9'h007;  8'h46: key = 9'h17C;  8'h47: key = 9'h07E;
            8'h49: key = 9'h170;  8'h4A: key = 9'h16C;  8'h4B: key = 9'h17D;  8'h4C: key = 9'h171;
            8'h4D: key = 9'h169;  8'h4E: key = 9'h17A;  8'h4F: key = 9'h174;  8'h50: key = 9'h16B;
            8'h51: key = 9'h172;  8'h52: key = 9'h175;  8'h53: key = 9'h077;  8'h54: key = 9'h14A;
            8'h55: key = 9'h07C;  8'h56: key = 9'h07B;  8'h57: key = 9'h079;  8'h58: key = 9'h15A;
            8'h59: key = 9'h069;  8'h5A: key = 9'h072;  8'h5B: key = 9'h07A;  8'h5C: key = 9'h06B;
            8'h5D: key = 9'h073;  8'h5E: key = 9'h074;  8'h5F: key = 9'h06C;  8'h60: key = 9'h075;
            8'h61: key = 9'h07D;  8'h62: key = 9'h070;  8'h63: key = 9'h071;  8'h64: key = 9'h061;
            8'h65: key = 9'h12F;
            default: key = 9'h000;
        endcase
    end
    assign code_o = ps2_code_t'(is_mod_i ? MOD_CODES[usage_i[2:0]] : key);
endmodule

// File: rtl/hid_ps2_encoder.sv
// hid_ps2_encoder: diffs each new HID boot report against the previous one and
// emits PS/2 set-2 break codes then make codes, one byte per strobe with idle gaps.
module hid_ps2_encoder
    import hid_ps2_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kb_status,
    input  logic [7:0] kb_dat0,
    input  logic [7:0] kb_dat1,
    input  logic [7:0] kb_dat2,
    input  logic [7:0] kb_dat3,
    input  logic [7:0] kb_dat4,
    input  logic [7:0] kb_dat5,
    input  logic       report_valid,
    output logic [7:0] kb_scancode,
    output logic       kb_scancode_upd,
    output logic       busy
);
    state_e      state_q, state_d, ret_q, ret_d, adv_state;
    report_t     old_q, old_d, new_q, new_d, pend_q, pend_d, in_rep, src, ref_r, oth_r;
    logic        pend_v_q, pend_v_d, brk_q, brk_d, upd_q, upd_d;
    logic [3:0]  idx_q, idx_d, adv_idx;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  sc_q, sc_d, usage;
    logic        slot_mod, last, present, active, hit, key_seen;
    ps2_code_t   lut;

    assign in_rep = {kb_status, kb_dat5, kb_dat4, kb_dat3, kb_dat2, kb_dat1, kb_dat0};
    assign src = report_valid ? in_rep : pend_q;
    // break phase walks the old report looking into the new one; make phase the reverse
    assign ref_r = brk_q ? old_q : new_q;
    assign oth_r = brk_q ? new_q : old_q;
    assign slot_mod = idx_q < 4'd8;
    assign usage = slot_mod ? {5'd0, idx_q[2:0]} : ref_r.keys[idx_q[2:0]];
    assign active = slot_mod ? ref_r.mods[idx_q[2:0]] : usage != 8'h00;
    assign present = slot_mod ? oth_r.mods[idx_q[2:0]] : key_seen;
    assign hit = active && !present && lut.code != 8'h00;
    assign last = idx_q == 4'd13;
    assign adv_idx = last ? 4'd0 : idx_q + 4'd1;
    assign adv_state = last ? (brk_q ? MK_SCAN : COMMIT) : (brk_q ? BRK_SCAN : MK_SCAN);

    hid_ps2_lut u_lut (.is_mod_i(slot_mod), .usage_i(usage), .code_o(lut));

    always_comb begin
        key_seen = 1'b0;
        for (int j = 0; j < 6; j++) key_seen = key_seen | (oth_r.keys[j] == usage);
    end

    always_comb begin
        state_d = state_q;
        ret_d = ret_q;
        old_d = old_q;
        new_d = new_q;
        pend_d = pend_q;
        pend_v_d = pend_v_q;
        idx_d = idx_q;
        brk_d = brk_q;
        gap_d = gap_q;
        sc_d = sc_q;
        upd_d = 1'b0;
        if (report_valid && state_q != IDLE) begin
            pend_d = in_rep;
            pend_v_d = 1'b1;
        end
        case (state_q)
            IDLE: if (report_valid || pend_v_q) begin
                pend_v_d = 1'b0;
                if (src.keys != {6{8'h01}}) begin
                    new_d = src;
                    idx_d = 4'd0;
                    brk_d = 1'b1;
                    state_d = BRK_SCAN;
                end
            end
            BRK_SCAN, MK_SCAN: if (hit) begin
                state_d = lut.ext ? EMIT_E0 : (brk_q ? EMIT_F0 : EMIT_CODE);
            end else begin
                state_d = adv_state;
                idx_d = adv_idx;
                brk_d = brk_q && !last;
            end
            EMIT_E0, EMIT_F0, EMIT_CODE: begin
                upd_d = 1'b1;
                sc_d = state_q == EMIT_E0 ? 8'hE0 : state_q == EMIT_F0 ? 8'hF0 : lut.code;
                ret_d = state_q == EMIT_E0 ? (brk_q ? EMIT_F0 : EMIT_CODE) : state_q == EMIT_F0 ? EMIT_CODE : adv_state;
                state_d = GAP_CYCLES == 0 ? ret_d : GAP;
                gap_d = 16'd0;
                if (state_q == EMIT_CODE) begin
                    idx_d = adv_idx;
                    brk_d = brk_q && !last;
                end
            end
            GAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == 16'(GAP_CYCLES - 1)) state_d = ret_q;
            end
            COMMIT: begin
                old_d = new_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ret_q <= IDLE;
            old_q <= '0;
            new_q <= '0;
            pend_q <= '0;
            pend_v_q <= 1'b0;
            idx_q <= 4'd0;
            brk_q <= 1'b0;
            gap_q <= 16'd0;
            sc_q <= 8'h00;
            upd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q <= ret_d;
            old_q <= old_d;
            new_q <= new_d;
            pend_q <= pend_d;
            pend_v_q <= pend_v_d;
            idx_q <= idx_d;
            brk_q <= brk_d;
            gap_q <= gap_d;
            sc_q <= sc_d;
            upd_q <= upd_d;
        end
    end

    assign kb_scancode = sc_q;
    assign kb_scancode_upd = upd_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_hid_ps2_encoder.sv
// tb_hid_ps2_encoder: directed and randomized bench for hid_ps2_encoder with a
// report-diff reference model; a second instance runs with no inter-byte gap.
module tb_hid_ps2_encoder;
    localparam int GAP = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic report_valid = 1'b0;
    logic [7:0] kb_status = 8'h00;
    logic [7:0] kb_dat0 = 8'h00, kb_dat1 = 8'h00, kb_dat2 = 8'h00, kb_dat3 = 8'h00, kb_dat4 = 8'h00, kb_dat5 = 8'h00;
    logic [7:0] sc, sc0;
    logic upd, upd0, busy, busy0;
    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] got_q[$], got0_q[$], exp_q[$];
    int tim_q[$], tim0_q[$];
    logic [7:0] m_mod = 8'h00;
    logic [5:0][7:0] m_key = '0;
    logic [7:0] pool [11] = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h1E, 8'h28, 8'h29, 8'h2C, 8'h4F, 8'h50, 8'hE8};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (upd) begin got_q.push_back(sc); tim_q.push_back(cyc); end
        if (upd0) begin got0_q.push_back(sc0); tim0_q.push_back(cyc); end
    end

    hid_ps2_encoder #(.GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .reset(reset), .kb_status(kb_status),
        .kb_dat0(kb_dat0), .kb_dat1(kb_dat1), .kb_dat2(kb_dat2), .kb_dat3(kb_dat3), .kb_dat4(kb_dat4), .kb_dat5(kb_dat5),
        .report_valid(report_valid), .kb_scancode(sc), .kb_scancode_upd(upd), .busy(busy));
    hid_ps2_encoder #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .kb_status(kb_status),
        .kb_dat0(kb_dat0), .kb_dat1(kb_dat1), .kb_dat2(kb_dat2), .kb_dat3(kb_dat3), .kb_dat4(kb_dat4), .kb_dat5(kb_dat5),
        .report_valid(report_valid), .kb_scancode(sc0), .kb_scancode_upd(upd0), .busy(busy0));

    function automatic logic [8:0] ref_code(input bit is_mod, input logic [7:0] u);
        if (is_mod) begin
            case (u[2:0])
                3'd0: return 9'h014;
                3'd1: return 9'h012;
                3'd2: return 9'h011;
                3'd3: return 9'h11F;
                3'd4: return 9'h114;
                3'd5: return 9'h059;
                3'd6: return 9'h111;
                default: return 9'h127;
            endcase
        end
        case (u)
            8'h04: return 9'h01C;
            8'h05: return 9'h032;
            8'h1E: return 9'h016;
            8'h28: return 9'h05A;
            8'h29: return 9'h076;
            8'h2C: return 9'h029;
            8'h4F: return 9'h174;
            8'h50: return 9'h16B;
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [63:0] pack(input logic [7:0] q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[55:0], q[i]};
        return v;
    endfunction

    // Appends the expected byte stream for moving from the model's held report to n.
    task automatic model_diff(input logic [7:0] nmod, input logic [5:0][7:0] nk);
        logic [7:0] am, bm;
        logic [5:0][7:0] ak, bk;
        logic [8:0] c;
        bit seen;
        if (nk == {6{8'h01}}) return;
        for (int p = 0; p < 2; p++) begin
            am = p == 0 ? m_mod : nmod;
            bm = p == 0 ? nmod : m_mod;
            ak = p == 0 ? m_key : nk;
            bk = p == 0 ? nk : m_key;
            for (int s = 0; s < 14; s++) begin
                if (s < 8) begin
                    seen = bm[s];
                    c = am[s] ? ref_code(1, 8'(s)) : 9'h000;
                end else begin
                    seen = 0;
                    for (int l = 0; l < 6; l++) if (bk[l] == ak[s-8]) seen = 1;
                    c = ref_code(0, ak[s-8]);
                end
                if (!seen && c[7:0] != 8'h00) begin
                    if (c[8]) exp_q.push_back(8'hE0);
                    if (p == 0) exp_q.push_back(8'hF0);
                    exp_q.push_back(c[7:0]);
                end
            end
        end
        m_mod = nmod;
        m_key = nk;
    endtask

    task automatic clear();
        got_q.delete(); got0_q.delete(); tim_q.delete(); tim0_q.delete(); exp_q.delete();
    endtask

    task automatic send(input logic [7:0] mod, input logic [5:0][7:0] k);
        @(negedge clk);
        kb_status = mod;
        {kb_dat5, kb_dat4, kb_dat3, kb_dat2, kb_dat1, kb_dat0} = k;
        report_valid = 1'b1;
        @(negedge clk);
        report_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int n = 0; n < 5000 && quiet < 4; n++) begin
            @(negedge clk);
            quiet = (busy || busy0) ? 0 : quiet + 1;
        end
        checks++;
        if (quiet < 4) begin errors++; $display("FAIL wait_idle: busy still high after 5000 cycles"); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sc, upd, busy, sc0, upd0, busy0} !== 18'd0)
            begin errors++; $display("FAIL reset_state: got sc=%h upd=%b busy=%b sc0=%h upd0=%b busy0=%b, need all 0", sc, upd, busy, sc0, upd0, busy0); end
        reset = 1'b0;
    endtask

    task automatic test_press_release();
        clear(); model_diff(8'h00, {40'd0, 8'h04}); send(8'h00, {40'd0, 8'h04}); wait_idle();
        checks++;
        if (got_q.size() != 1 || pack(got_q) !== 64'h1C) begin errors++; $display("FAIL press: got %0d bytes %h, need 1C", got_q.size(), pack(got_q)); end
        clear(); model_diff(8'h00, '0); send(8'h00, '0); wait_idle();
        checks++;
        if (got_q.size() != 2 || pack(got_q) !== 64'hF01C) begin errors++; $display("FAIL release: got %0d bytes %h, need F01C", got_q.size(), pack(got_q)); end
        checks++;
        if (got_q.size() == 2 && tim_q[1] - tim_q[0] != GAP + 1) begin errors++; $display("FAIL release_gap: strobe spacing %0d, need %0d", tim_q[1] - tim_q[0], GAP + 1); end
        checks++;
        if (sc !== 8'h1C || upd !== 1'b0) begin errors++; $display("FAIL hold: scancode %h upd %b, need 1C/0", sc, upd); end
        checks++;
        if (got0_q.size() != 2 || pack(got0_q) !== 64'hF01C || tim0_q[1] - tim0_q[0] != 1)
            begin errors++; $display("FAIL gap0_release: got %0d bytes %h, need F01C on consecutive clocks", got0_q.size(), pack(got0_q)); end
    endtask

    task automatic test_extended();
        clear(); model_diff(8'h00, {40'd0, 8'h4F}); send(8'h00, {40'd0, 8'h4F}); wait_idle();
        checks++;
        if (got_q.size() != 2 || pack(got_q) !== 64'hE074) begin errors++; $display("FAIL ext_press: got %0d bytes %h, need E074", got_q.size(), pack(got_q)); end
        clear(); model_diff(8'h00, '0); send(8'h00, '0); wait_idle();
        checks++;
        if (got_q.size() != 3 || pack(got_q) !== 64'hE0F074) begin errors++; $display("FAIL ext_release: got %0d bytes %h, need E0F074", got_q.size(), pack(got_q)); end
        checks++;
        if (got_q.size() == 3 && (tim_q[1] - tim_q[0] != GAP + 1 || tim_q[2] - tim_q[1] != GAP + 1))
            begin errors++; $display("FAIL ext_gap: spacing %0d/%0d, need %0d", tim_q[1] - tim_q[0], tim_q[2] - tim_q[1], GAP + 1); end
        checks++;
        if (got0_q.size() != 3 || pack(got0_q) !== 64'hE0F074 || tim0_q[2] - tim0_q[0] != 2)
            begin errors++; $display("FAIL gap0_ext: got %0d bytes %h, need E0F074 on consecutive clocks", got0_q.size(), pack(got0_q)); end
    endtask

    task automatic test_modifier();
        clear(); model_diff(8'h02, {40'd0, 8'h04}); send(8'h02, {40'd0, 8'h04}); wait_idle();
        checks++;
        if (got_q.size() != 2 || pack(got_q) !== 64'h121C) begin errors++; $display("FAIL mod_press: got %0d bytes %h, need 121C", got_q.size(), pack(got_q)); end
        clear(); model_diff(8'h00, '0); send(8'h00, '0); wait_idle();
        checks++;
        if (got_q.size() != 4 || pack(got_q) !== 64'hF012F01C) begin errors++; $display("FAIL mod_release: got %0d bytes %h, need F012F01C", got_q.size(), pack(got_q)); end
    endtask

    task automatic test_rollover();
        bit saw_busy = 0;
        clear(); model_diff(8'h00, {40'd0, 8'h04}); send(8'h00, {40'd0, 8'h04}); wait_idle();
        clear(); model_diff(8'h00, {6{8'h01}}); send(8'h00, {6{8'h01}});
        repeat (40) begin @(negedge clk); saw_busy |= busy | busy0; end
        checks++;
        if (saw_busy || got_q.size() != 0) begin errors++; $display("FAIL rollover: busy seen %b, %0d strobes, need 0/0", saw_busy, got_q.size()); end
        clear(); model_diff(8'h00, '0); send(8'h00, '0); wait_idle();
        checks++;
        if (got_q.size() != 2 || pack(got_q) !== 64'hF01C) begin errors++; $display("FAIL rollover_release: got %0d bytes %h, need F01C", got_q.size(), pack(got_q)); end
    endtask

    task automatic test_back_to_back();
        clear();
        model_diff(8'h05, {16'd0, 8'h28, 8'h1E, 8'h05, 8'h04});
        send(8'h05, {16'd0, 8'h28, 8'h1E, 8'h05, 8'h04});
        repeat (3) @(negedge clk);
        send(8'hFF, {6{8'h04}});
        send(8'h80, {40'd0, 8'h4F});
        send(8'h01, {32'd0, 8'h2C, 8'h05});
        model_diff(8'h01, {32'd0, 8'h2C, 8'h05});
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL overlap count: got %0d bytes, need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL overlap byte %0d: got %h, need %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] mod;
        logic [5:0][7:0] k;
        for (int it = 0; it < 25; it++) begin
            mod = 8'($urandom);
            for (int j = 0; j < 6; j++) k[j] = pool[$urandom_range(10, 0)];
            if ($urandom_range(7, 0) == 0) k = {6{8'h01}};
            clear(); model_diff(mod, k); send(mod, k); wait_idle();
            checks++;
            if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random[%0d] count: got %0d bytes, need %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random[%0d] byte %0d: got %h, need %h", it, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear();
        send(~m_mod, {8'h28, 8'h1E, 8'h05, 8'h04, 8'h50, 8'h4F});
        while (got_q.size() == 0 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (got_q.size() == 0) begin errors++; $display("FAIL reset_mid_start: no strobe within 300 cycles, need at least 1"); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sc, upd, busy} !== 10'd0) begin errors++; $display("FAIL reset_mid_outputs: sc=%h upd=%b busy=%b, need 0", sc, upd, busy); end
        clear();
        reset = 1'b0;
        m_mod = 8'h00;
        m_key = '0;
        repeat (300) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || got0_q.size() != 0) begin errors++; $display("FAIL reset_mid_quiet: %0d/%0d strobes after reset, need 0", got_q.size(), got0_q.size()); end
        clear(); send(8'h00, '0); wait_idle();
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL reset_empty: got %0d bytes %h, need none", got_q.size(), pack(got_q)); end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_extended();
        test_modifier();
        test_rollover();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
